sig_deint: RTL and testbench

SIG_DEINT -- requirements
Module: sig_deint

---
 rtl/sig_deint_pkg.sv | 34 +++
 rtl/sig_deint_hist.sv | 56 +++++
 rtl/sig_deint.sv | 198 +++++++++++++++++++
 tb/tb_sig_deint.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_deint_pkg.sv
// -----------------------------------------------------------------------------
// sig_deint_pkg
// Shared definitions for the moving-sum de-integrator signal path:
//   - default widths and window length
//   - saturation limit helpers and the default output-range limits
//   - FSM state encoding
// -----------------------------------------------------------------------------
package sig_deint_pkg;

    // Default data-path geometry.
    localparam int DEF_DIN_W  = 13;  // signed moving-sum input width
    localparam int DEF_DOUT_W = 9;   // signed reconstructed sample width
    localparam int DEF_TAPS   = 16;  // moving-sum window length (power of two)

    // Largest / smallest value representable in a w-bit two's complement word.
    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

    // Clip limits for the default output width: [-256, +255].
    localparam int SAT_MAX = sat_hi(DEF_DOUT_W);
    localparam int SAT_MIN = sat_lo(DEF_DOUT_W);

    // IDLE: history clear, no sample accepted yet. RUN: stream in progress.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sig_deint_hist.sv
// -----------------------------------------------------------------------------
// sig_hist_buf
// Circular history of reconstructed samples x[n-TAPS .. n-1].
// One entry register per tap; synchronous write, combinational read at the
// same address, synchronous clear of every entry.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears all entries)
//   clr    in   synchronous clear of all entries (wins over a write)
//   we     in   write enable
//   addr   in   entry index for both the read and the write
//   wdata  in   value written to entry addr on we
//   rdata  out  current content of entry addr (before this cycle's write)
// -----------------------------------------------------------------------------
module sig_hist_buf
    import sig_deint_pkg::*;
#(
    parameter int DEPTH = DEF_TAPS,
    parameter int WIDTH = DEF_DOUT_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic signed [WIDTH-1:0] wdata,
    output logic signed [WIDTH-1:0] rdata
);

    logic signed [WIDTH-1:0] rd_arr [DEPTH];

    // Each entry is an independent register so that the whole buffer can be
    // cleared in a single cycle on start-of-stream.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic signed [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (clr) begin
                    entry_reg <= '0;
                end else if (we && (addr == AW'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign rd_arr[gi] = entry_reg;
        end
    endgenerate

    assign rdata = rd_arr[addr];

endmodule

// File: rtl/sig_deint.sv
// -----------------------------------------------------------------------------
// sig_deint
// Recovers x[n] from a TAPS-point moving sum y[n] = sum(x[n-TAPS+1 .. n]):
//     x[n] = y[n] - y[n-1] + x[n-TAPS]
// with y[-1] = 0 and x[n<0] = 0 at the start of every stream.
//
// Pipeline:
//   stage 1 : d = Yin - yprev                       (DIN_W+1 bits)
//   stage 2 : Xout = sat(d + x[n-TAPS])             (DIN_W+2 bits, clipped
//             to DOUT_W); the clipped value is written back as x[n].
// out_valid follows the accepting in_valid cycle by exactly two cycles.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   Yin carries a new moving-sum sample
//   Yin       in   signed moving sum y[n]
//   sync      in   start-of-stream; clears history and flushes the pipeline
//   out_valid out  one-cycle pulse per reconstructed sample
//   Xout      out  reconstructed signed sample x[n] (held between pulses)
//   warm      out  TAPS samples processed since last sync/reset
//   err       out  sticky flag: some sample was clipped since last sync/reset
// -----------------------------------------------------------------------------
module sig_deint
    import sig_deint_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int DOUT_W = DEF_DOUT_W,
    parameter int TAPS   = DEF_TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DIN_W-1:0]  Yin,
    input  logic                     sync,
    output logic                     out_valid,
    output logic signed [DOUT_W-1:0] Xout,
    output logic                     warm,
    output logic                     err
);

    localparam int D_W   = DIN_W + 1;          // stage-1 difference width
    localparam int SUM_W = DIN_W + 2;          // stage-2 pre-clip width
    localparam int PTR_W = $clog2(TAPS);
    localparam int CNT_W = $clog2(TAPS) + 1;   // must be able to hold TAPS

    // Clip limits follow the actual output width; the package values cover
    // the default configuration.
    localparam int X_MAX = (DOUT_W == DEF_DOUT_W) ? SAT_MAX : sat_hi(DOUT_W);
    localparam int X_MIN = (DOUT_W == DEF_DOUT_W) ? SAT_MIN : sat_lo(DOUT_W);

    localparam logic signed [SUM_W-1:0]  SUM_HI   = SUM_W'(X_MAX);
    localparam logic signed [SUM_W-1:0]  SUM_LO   = SUM_W'(X_MIN);
    localparam logic signed [DOUT_W-1:0] X_HI     = DOUT_W'(X_MAX);
    localparam logic signed [DOUT_W-1:0] X_LO     = DOUT_W'(X_MIN);
    localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(TAPS);

    // ---------------------------------------------------------------- state
    state_t state_reg, state_next;

    logic signed [DIN_W-1:0]  yprev_reg;
    logic signed [D_W-1:0]    d_reg;
    logic                     s1_valid_reg;

    logic [PTR_W-1:0]         ptr_reg;
    logic [CNT_W-1:0]         cnt_reg;

    logic                     out_valid_reg;
    logic signed [DOUT_W-1:0] xout_reg;
    logic                     warm_reg;
    logic                     err_reg;

    // ------------------------------------------------------------ datapath
    logic signed [DIN_W-1:0]  yprev_eff;
    logic signed [D_W-1:0]    d_next;
    logic signed [DOUT_W-1:0] hist_rd;
    logic signed [SUM_W-1:0]  sum_next;
    logic                     clip_hi;
    logic                     clip_lo;
    logic signed [DOUT_W-1:0] x_sat;
    logic                     s2_fire;
    logic [CNT_W-1:0]         cnt_next;

    // A sample arriving together with sync, or while no stream is running,
    // is the first of its stream, so its predecessor is taken as zero.
    assign yprev_eff = (sync || (state_reg == ST_IDLE)) ? '0 : yprev_reg;
    assign d_next    = D_W'(Yin) - D_W'(yprev_eff);

    // sync kills whatever sits in stage 1 so no pre-sync sample emerges.
    assign s2_fire   = s1_valid_reg && !sync;

    assign sum_next  = SUM_W'(d_reg) + SUM_W'(hist_rd);
    assign clip_hi   = (sum_next > SUM_HI);
    assign clip_lo   = (sum_next < SUM_LO);

    always_comb begin
        x_sat = sum_next[DOUT_W-1:0];
        if (clip_hi) begin
            x_sat = X_HI;
        end else if (clip_lo) begin
            x_sat = X_LO;
        end
    end

    assign cnt_next = (cnt_reg == CNT_FULL) ? cnt_reg : cnt_reg + 1'b1;

    // History is read at the write pointer (oldest entry, x[n-TAPS]) and the
    // clipped result replaces it at the end of the same cycle.
    sig_hist_buf #(
        .DEPTH (TAPS),
        .WIDTH (DOUT_W)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync),
        .we    (s2_fire),
        .addr  (ptr_reg),
        .wdata (x_sat),
        .rdata (hist_rd)
    );

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sync && !in_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ stage 1 (d)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yprev_reg    <= '0;
            d_reg        <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                yprev_reg <= Yin;
                d_reg     <= d_next;
            end else if (sync) begin
                yprev_reg <= '0;
            end
        end
    end

    // ---------------------------------------------- stage 2 (x, flags)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            xout_reg      <= '0;
            warm_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            out_valid_reg <= s2_fire;
            if (sync) begin
                ptr_reg  <= '0;
                cnt_reg  <= '0;
                warm_reg <= 1'b0;
                err_reg  <= 1'b0;
            end else if (s2_fire) begin
                ptr_reg  <= ptr_reg + 1'b1;
                cnt_reg  <= cnt_next;
                xout_reg <= x_sat;
                warm_reg <= (cnt_next == CNT_FULL);
                if (clip_hi || clip_lo) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign Xout      = xout_reg;
    assign warm      = warm_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_sig_deint.sv
// -----------------------------------------------------------------------------
// tb_sig_deint
// Self-checking bench for sig_deint. A reference model keeps the current
// stream's reconstructed samples in a queue and applies
// x[n] = y[n] - y[n-1] + x[n-16] with clipping to [-256, 255]; expected
// outputs are delayed two cycles and compared every cycle. Directed streams
// are followed by a randomized run with occasional sync and reset.
// -----------------------------------------------------------------------------
module tb_sig_deint;

    localparam int DIN_W  = 13;
    localparam int DOUT_W = 9;
    localparam int TAPS   = 16;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DIN_W-1:0]  Yin = '0;
    logic                     sync = 1'b0;
    logic                     out_valid;
    logic signed [DOUT_W-1:0] Xout;
    logic                     warm;
    logic                     err;

    sig_deint #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W),
        .TAPS   (TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Yin       (Yin),
        .sync      (sync),
        .out_valid (out_valid),
        .Xout      (Xout),
        .warm      (warm),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct {
        bit v;    // a sample emerges
        bit clr;  // sync took effect: warm/err drop
        int x;
        bit w;
        bit e;
    } ent_t;

    int   m_yprev;
    int   m_xq[$];   // last TAPS reconstructed samples of the current stream
    int   m_n;
    bit   m_err;
    ent_t p1, p2;    // expected outputs one and two cycles ahead
    int   held_x;
    bit   held_w, held_e;
    int   got_x[$];  // observed Xout on each out_valid pulse

    function automatic void model_clear_stream();
        m_yprev = 0;
        m_xq.delete();
        m_n     = 0;
        m_err   = 1'b0;
    endfunction

    // One clock cycle: check what is visible now, advance the model, drive
    // the new inputs, then wait for the next falling edge.
    task automatic step(input bit iv, input int y, input bit sy);
        ent_t cur;
        int   xo;
        int   s;
        if (p2.v) begin
            held_x = p2.x;
            held_w = p2.w;
            held_e = p2.e;
        end else if (p2.clr) begin
            held_w = 1'b0;
            held_e = 1'b0;
        end
        check_val("out_valid", int'(out_valid), int'(p2.v));
        check_val("Xout", int'(Xout), held_x);
        check_val("warm", int'(warm), int'(held_w));
        check_val("err", int'(err), int'(held_e));
        if (out_valid) got_x.push_back(int'(Xout));

        p2  = p1;
        cur = '{v: 1'b0, clr: 1'b0, x: 0, w: 1'b0, e: 1'b0};
        if (sy) begin
            p2.v   = 1'b0;
            p2.clr = 1'b1;
            model_clear_stream();
        end
        if (iv) begin
            xo = (m_xq.size() >= TAPS) ? m_xq[m_xq.size() - TAPS] : 0;
            s  = y - m_yprev + xo;
            if (s > 255) begin
                s = 255;
                m_err = 1'b1;
            end else if (s < -256) begin
                s = -256;
                m_err = 1'b1;
            end
            m_xq.push_back(s);
            if (m_xq.size() > TAPS) void'(m_xq.pop_front());
            m_yprev = y;
            m_n++;
            cur.v = 1'b1;
            cur.x = s;
            cur.w = (m_n >= TAPS);
            cur.e = m_err;
        end
        p1 = cur;

        in_valid = iv;
        Yin      = DIN_W'(y);
        sync     = sy;
        @(negedge clk);
    endtask

    // Pulse reset for one cycle, checking outputs drop immediately.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sync     = 1'b0;
        #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_Xout", int'(Xout), 0);
        check_val("rst_warm", int'(warm), 0);
        check_val("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_stream();
        p1     = '{v: 1'b0, clr: 1'b0, x: 0, w: 1'b0, e: 1'b0};
        p2     = p1;
        held_x = 0;
        held_w = 1'b0;
        held_e = 1'b0;
    endtask

    task automatic drain();
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Constant x = 5: ramping sum that then plateaus at 80.
        got_x.delete();
        for (int i = 1; i <= 16; i++) step(1'b1, 5 * i, 1'b0);
        step(1'b1, 80, 1'b0);
        step(1'b1, 80, 1'b0);
        drain();
        check_val("const_count", got_x.size(), 18);
        foreach (got_x[i]) check_val("const_x", got_x[i], 5);
        check_val("const_warm", int'(warm), 1);

        // Impulse: 100 x16 then 0 x16.
        step(1'b0, 0, 1'b1);
        got_x.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 100, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0);
        drain();
        check_val("imp_count", got_x.size(), 32);
        foreach (got_x[i]) check_val("imp_x", got_x[i], (i == 0) ? 100 : 0);
        check_val("imp_err", int'(err), 0);

        // Saturation: 0 then 4095 clips to 255 and err stays set until sync.
        step(1'b0, 0, 1'b1);
        got_x.delete();
        step(1'b1, 0, 1'b0);
        step(1'b1, 4095, 1'b0);
        drain();
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
        check_val("sat_count", got_x.size(), 2);
        check_val("sat_x0", got_x[0], 0);
        check_val("sat_x1", got_x[1], 255);
        check_val("sat_err_sticky", int'(err), 1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        check_val("sat_err_cleared", int'(err), 0);

        // Gapped input: 7,14,21 with three idle cycles in between.
        got_x.delete();
        step(1'b1, 7, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0);
        step(1'b1, 14, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0);
        step(1'b1, 21, 1'b0);
        drain();
        check_val("gap_count", got_x.size(), 3);
        foreach (got_x[i]) check_val("gap_x", got_x[i], 7);

        // Sync mid-stream with a new first sample in the same cycle.
        step(1'b0, 0, 1'b1);
        got_x.delete();
        for (int i = 1; i <= 10; i++) step(1'b1, 5 * i, 1'b0);
        step(1'b1, 3, 1'b1);
        drain();
        check_val("sync_count", got_x.size(), 10);
        check_val("sync_x", got_x[got_x.size() - 1], 3);
        check_val("sync_warm", int'(warm), 0);
        check_val("sync_err", int'(err), 0);

        // Reset with two samples in flight, then a fresh stream.
        step(1'b1, 20, 1'b0);
        step(1'b1, 40, 1'b0);
        do_reset();
        got_x.delete();
        step(1'b1, 9, 1'b0);
        drain();
        check_val("rst_count", got_x.size(), 1);
        check_val("rst_x", got_x[0], 9);

        // Randomized stream with occasional sync and reset.
        for (int i = 0; i < 3000; i++) begin
            bit iv;
            bit sy;
            int y;
            iv = ($urandom_range(0, 9) < 7);
            sy = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 8191)) - 4096;
            else                           y = int'($urandom_range(0, 400)) - 200;
            if ($urandom_range(0, 399) == 0) do_reset();
            else                             step(iv, y, sy);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
